// File: rtl/sudoku_pkg.sv
// Shared constants, ROM word layout and loader state encoding for the puzzle path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sudoku_pkg;

    localparam int CELLS        = 81;
    localparam int DIGIT_W      = 4;
    localparam int MAP_W        = CELLS * DIGIT_W;
    localparam int CELL_W       = 7;

    // ROM word fields
    localparam int ROM_W        = 6;
    localparam int DIGIT_LSB    = 0;
    localparam int VIS_EASY_BIT = 4;
    localparam int VIS_HARD_BIT = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_COMMIT = 2'd2
    } loader_state_e;

    // A legal solution digit is 1..9; anything else marks corrupt ROM content.
    function automatic logic digit_bad(input logic [DIGIT_W-1:0] d);
        return (d == '0) || (d > DIGIT_W'(9));
    endfunction

endpackage

// File: rtl/puzzle_addr_gen.sv
// ROM address sequencer: walks pid*81 .. pid*81+80, one address per cycle.
// Latency: first address registered at the start edge, last one 80 cycles later.
// Backpressure: none; once started it runs to the last cell, address then holds.
module puzzle_addr_gen
    import sudoku_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int PID_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [PID_W-1:0]  pid_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic [CELL_W-1:0] cell_o,
    output logic              active_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] base_d;
    logic [ADDR_W-1:0] addr_q;
    logic [CELL_W-1:0] cnt_q;
    logic              active_q;

    // pid*81 as shift-add; the parameter constraint keeps it inside ADDR_W bits
    assign base_d = (ADDR_W'(pid_i) << 6) + (ADDR_W'(pid_i) << 4) + ADDR_W'(pid_i);

    // Cell counter and address register; address holds after the last cell
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start_i) begin
            addr_q   <= base_d;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (cnt_q == CELL_W'(CELLS - 1)) begin
                active_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_q + CELL_W'(1);
                addr_q <= addr_q + ADDR_W'(1);
            end
        end
    end

    assign rom_addr_o = addr_q;
    assign cell_o     = cnt_q;
    assign active_o   = active_q;
    assign last_o     = active_q && (cnt_q == CELL_W'(CELLS - 1));

endmodule

// File: rtl/puzzle_loader.sv
// Loads one puzzle from the ROM into shadow registers and commits map + hint mask atomically.
// Latency: fixed 84 cycles from accepted load_req to the done pulse.
// Backpressure: none; requests while busy (including the commit edge) are dropped.
module puzzle_loader
    import sudoku_pkg::*;
#(
    parameter int NUM_PUZZLES = 4,
    parameter int ADDR_W      = 9,
    parameter int PID_W       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req_i,
    input  logic              difficulty_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [ROM_W-1:0]  rom_data_i,
    output logic [MAP_W-1:0]  selected_map_o,
    output logic [CELLS-1:0]  selected_visibility_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              rom_error_o,
    output logic [PID_W-1:0]  puzzle_id_o
);

    loader_state_e state_q;

    logic [PID_W-1:0]   sel_cnt_q;
    logic [PID_W-1:0]   sel_cnt_d;
    logic [PID_W-1:0]   pid_q;
    logic               diff_q;

    logic               accept;
    logic [CELL_W-1:0]  gen_cell;
    logic               gen_active;
    logic               gen_last;

    // Read pipeline: tags the ROM word arriving one cycle after its address
    logic               rd_vld_q;
    logic               rd_last_q;
    logic [CELL_W-1:0]  rd_idx_q;
    logic [8:0]         map_lsb;

    logic [DIGIT_W-1:0] rom_digit;
    logic               rom_vis;

    logic [MAP_W-1:0]   shadow_map_q;
    logic [CELLS-1:0]   shadow_vis_q;
    logic [MAP_W-1:0]   selected_map_q;
    logic [CELLS-1:0]   selected_vis_q;
    logic               busy_q;
    logic               done_q;
    logic               rom_error_q;
    logic [PID_W-1:0]   puzzle_id_q;

    assign accept = (state_q == ST_IDLE) && load_req_i;

    // Selection counter wraps at NUM_PUZZLES, so player timing picks the puzzle
    always_comb begin
        sel_cnt_d = sel_cnt_q + PID_W'(1);
        if (sel_cnt_q == PID_W'(NUM_PUZZLES - 1)) begin
            sel_cnt_d = '0;
        end
    end

    // Free-running selection counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_cnt_q <= '0;
        end else begin
            sel_cnt_q <= sel_cnt_d;
        end
    end

    puzzle_addr_gen #(
        .ADDR_W (ADDR_W),
        .PID_W  (PID_W)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .start_i    (accept),
        .pid_i      (sel_cnt_q),
        .rom_addr_o (rom_addr_o),
        .cell_o     (gen_cell),
        .active_o   (gen_active),
        .last_o     (gen_last)
    );

    // Delay the address tag by the ROM's one-cycle read latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            rd_idx_q  <= '0;
        end else begin
            rd_vld_q  <= gen_active;
            rd_last_q <= gen_last;
            rd_idx_q  <= gen_cell;
        end
    end

    // Each cell occupies four map bits
    assign map_lsb   = {rd_idx_q, 2'b00};
    assign rom_digit = rom_data_i[DIGIT_LSB +: DIGIT_W];
    assign rom_vis   = diff_q ? rom_data_i[VIS_HARD_BIT] : rom_data_i[VIS_EASY_BIT];

    // Loader FSM: accept, capture 81 cells into shadow, commit atomically
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            pid_q          <= '0;
            diff_q         <= 1'b0;
            shadow_map_q   <= '0;
            shadow_vis_q   <= '0;
            selected_map_q <= '0;
            selected_vis_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            rom_error_q    <= 1'b0;
            puzzle_id_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_req_i) begin
                        pid_q          <= sel_cnt_q;
                        diff_q         <= difficulty_i;
                        // Never let the controller see the previous puzzle's mask mid-load
                        selected_vis_q <= '0;
                        rom_error_q    <= 1'b0;
                        busy_q         <= 1'b1;
                        state_q        <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (rd_vld_q) begin
                        // Bad digits are flagged but kept as-is for debug visibility
                        shadow_map_q[map_lsb +: DIGIT_W] <= rom_digit;
                        shadow_vis_q[rd_idx_q]           <= rom_vis;
                        if (digit_bad(rom_digit)) begin
                            rom_error_q <= 1'b1;
                        end
                        if (rd_last_q) begin
                            state_q <= ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    selected_map_q <= shadow_map_q;
                    puzzle_id_q    <= pid_q;
                    // An empty mask would stall the controller; give cell 0 and flag it
                    if (shadow_vis_q == '0) begin
                        selected_vis_q <= {{(CELLS-1){1'b0}}, 1'b1};
                        rom_error_q    <= 1'b1;
                    end else begin
                        selected_vis_q <= shadow_vis_q;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign selected_map_o        = selected_map_q;
    assign selected_visibility_o = selected_vis_q;
    assign busy_o                = busy_q;
    assign done_o                = done_q;
    assign rom_error_o           = rom_error_q;
    assign puzzle_id_o           = puzzle_id_q;

endmodule

// File: tb/tb_puzzle_loader.sv
// Self-checking bench for puzzle_loader: random load requests, ROM model, scoreboard.
// Latency: expects done 84 cycles after each accepted request.
// Backpressure: issues stray requests mid-load and at the commit edge; they must be dropped.
module tb_puzzle_loader;

    localparam int NP = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load_req = 1'b0;
    logic         difficulty = 1'b0;
    logic [8:0]   rom_addr;
    logic [5:0]   rom_data = 6'd0;
    logic [323:0] sel_map;
    logic [80:0]  sel_vis;
    logic         busy;
    logic         done;
    logic         rom_error;
    logic [1:0]   puzzle_id;

    always #5 clk = ~clk;

    puzzle_loader #(
        .NUM_PUZZLES (NP),
        .ADDR_W      (9),
        .PID_W       (2)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .load_req_i            (load_req),
        .difficulty_i          (difficulty),
        .rom_addr_o            (rom_addr),
        .rom_data_i            (rom_data),
        .selected_map_o        (sel_map),
        .selected_visibility_o (sel_vis),
        .busy_o                (busy),
        .done_o                (done),
        .rom_error_o           (rom_error),
        .puzzle_id_o           (puzzle_id)
    );

    // Synchronous puzzle ROM, one-cycle read latency
    logic [5:0] rom_mem [0:NP*81-1];
    always @(posedge clk) begin
        rom_data <= (int'(rom_addr) < NP*81) ? rom_mem[rom_addr] : 6'd0;
    end

    // Rising edges since reset release; selection before edge n is (n-1) mod NP
    int cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        logic [323:0] map;
        logic [80:0]  vis;
        logic         err;
        int           pid;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [323:0] act, input logic [323:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    endtask

    // Expected commit from the puzzle rules applied to the ROM contents
    function automatic exp_t model(input int pid, input logic diff, input int acc);
        exp_t       e;
        logic [5:0] w;
        e.map = '0;
        e.vis = '0;
        e.err = 1'b0;
        for (int c = 0; c < 81; c++) begin
            w = rom_mem[pid*81 + c];
            e.map[c*4 +: 4] = w[3:0];
            e.vis[c] = diff ? w[5] : w[4];
            if (w[3:0] == 4'd0 || w[3:0] > 4'd9) e.err = 1'b1;
        end
        if (e.vis == '0) begin
            e.vis = 81'd1;
            e.err = 1'b1;
        end
        e.pid = pid;
        e.acc = acc;
        return e;
    endfunction

    // Monitor: address sequence, busy, and scoreboard pop on done
    int   mon_k;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            if (exp_q.size() > 0) begin
                mon_k = cyc - exp_q[0].acc;
                if (mon_k >= 0 && mon_k <= 80) check("rom_addr", rom_addr, exp_q[0].pid*81 + mon_k);
                if (mon_k >= 0 && mon_k <= 82) check("busy", busy, 1);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("stray_done", done, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("latency", cyc - mon_e.acc, 83);
                    check("map", sel_map, mon_e.map);
                    check("vis", sel_vis, mon_e.vis);
                    check("rom_error", rom_error, mon_e.err);
                    check("puzzle_id", puzzle_id, mon_e.pid);
                end
            end
        end
    end

    task automatic check_reset_state();
        check("rst_map", sel_map, 0);
        check("rst_vis", sel_vis, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", rom_error, 0);
        check("rst_pid", puzzle_id, 0);
        check("rst_addr", rom_addr, 0);
    endtask

    // Issue a request timed to pick puzzle `target`; optional stray traffic
    task automatic do_load(input int target, input logic diff, input int noise_at,
                           input bit commit_req, input bit reset_at40);
        int acc;
        @(negedge clk);
        while (cyc % NP != target) @(negedge clk);
        load_req   = 1'b1;
        difficulty = diff;
        acc = cyc + 1;
        exp_q.push_back(model(target, diff, acc));
        @(negedge clk);
        load_req   = 1'b0;
        difficulty = 1'($urandom_range(0, 1));
        if (reset_at40) begin
            while (cyc < acc + 40) @(negedge clk);
            #1 reset = 1'b1;
            #1 check_reset_state();
            exp_q.delete();
            @(negedge clk);
            @(negedge clk);
            reset = 1'b0;
            return;
        end
        if (noise_at > 0) begin
            while (cyc < acc + noise_at) @(negedge clk);
            load_req   = 1'b1;
            difficulty = ~diff;
            @(negedge clk);
            load_req   = 1'b0;
        end
        if (commit_req) begin
            while (cyc < acc + 82) @(negedge clk);
            load_req = 1'b1;
            @(negedge clk);
            load_req = 1'b0;
        end
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            check("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Puzzle 0: valid digits, no hints at all
        // Puzzle 1: digit (c%9)+1, easy hints on even cells, hard hints on cells 0 and 80
        // Puzzle 2: random valid content except an illegal digit in cell 5
        for (int c = 0; c < 81; c++) begin
            rom_mem[c]      = {2'b00, 4'($urandom_range(1, 9))};
            rom_mem[81 + c] = {1'(c == 0 || c == 80), 1'(c % 2 == 0), 4'(c % 9 + 1)};
            rom_mem[162 + c] = {2'($urandom_range(0, 3)), 4'($urandom_range(1, 9))};
        end
        rom_mem[162]     = {2'b11, 4'd7};
        rom_mem[162 + 5] = {2'b01, 4'hA};

        #23 check_reset_state();
        @(negedge clk);
        reset = 1'b0;

        do_load(1, 1'b0, 0, 1'b0, 1'b0);
        check("p1_cell10", sel_map[40 +: 4], 4'd2);

        do_load(1, 1'b1, 0, 1'b0, 1'b0);
        check("p1_hard_vis", sel_vis, 81'h1_0000_0000_0000_0000_0001);

        do_load(0, 1'($urandom_range(0, 1)), 0, 1'b0, 1'b0);
        check("empty_vis", sel_vis, 81'd1);
        check("empty_err", rom_error, 1);

        do_load(1, 1'b0, 30, 1'b1, 1'b0);
        check("err_cleared", rom_error, 0);

        do_load(2, 1'($urandom_range(0, 1)), 0, 1'b0, 1'b0);
        check("bad_digit_kept", sel_map[20 +: 4], 4'hA);
        check("bad_digit_err", rom_error, 1);

        do_load(2, 1'b0, 0, 1'b0, 1'b0);
        do_load(0, 1'b1, 0, 1'b0, 1'b0);
        check("wrap_pid", puzzle_id, 0);

        do_load(int'($urandom_range(0, NP-1)), 1'b0, 0, 1'b0, 1'b1);
        do_load(1, 1'b0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 8; n++) begin
            do_load(int'($urandom_range(0, NP-1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 81)) : 0,
                    1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/puzzle_loader.md
Name: puzzle_loader

Overview:
Producer side of the puzzle hand-off into the game controller. On a load request it picks a puzzle and streams its 81 cells out of a synchronous puzzle ROM. It then presents the assembled solution map (selected_map) and the difficulty-dependent hint mask (selected_visibility) to the game controller. Sits between the puzzle ROM and the game state machine, and is active while the game is in its loading state.

Parameters:
NUM_PUZZLES, 4, number of puzzles stored in ROM (each 81 consecutive words)
ADDR_W, 9, ROM address width; must satisfy NUM_PUZZLES*81 <= 2**ADDR_W
PID_W, 2, puzzle index width; must satisfy NUM_PUZZLES <= 2**PID_W

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
load_req  in  1  single-cycle load request from game controller
difficulty  in  1  0 = easy, 1 = hard; sampled only when a request is accepted
rom_addr  out  ADDR_W  ROM read address, registered
rom_data  in  6  ROM word: [3:0] solution digit, [4] visible when easy, [5] visible when hard
selected_map  out  324  solution digits, cell c = i*9+j at [c*4 +: 4]
selected_visibility  out  81  hint mask, bit c = 1 means cell c is given
busy  out  1  high from acceptance through the commit cycle
done  out  1  one-cycle pulse when outputs are committed
rom_error  out  1  sticky flag for bad ROM content in the last load
puzzle_id  out  PID_W  index of the puzzle committed last

Behaviour:
- Reset values: all outputs 0; state IDLE; sel_cnt 0. Reset mid-load aborts immediately with no partial commit.
- sel_cnt: free-running counter, 0..NUM_PUZZLES-1, wraps to 0. It increments every cycle in all states. Selection is therefore set by player timing.
- States: IDLE, FETCH, COMMIT.
- IDLE: at edge E0 with load_req=1, the request is accepted.
  - Latch pid = sel_cnt and diff = difficulty.
  - Clear selected_visibility to 0 at E0 so the controller never sees a stale nonzero mask.
  - selected_map holds its old value until commit.
  - Clear rom_error. Set busy=1. Go to FETCH.
- FETCH: rom_addr = pid*81 + k during the cycle after edge E_k, for k = 0..80.
  - The ROM has 1-cycle read latency. Cell k data is captured into shadow registers at E_{k+2}.
  - The digit goes to shadow_map[k*4 +: 4].
  - The mask bit is rom_data[4] if diff=0, else rom_data[5], and goes to shadow_vis[k].
  - After the capture of cell 80 at E82, go to COMMIT.
- COMMIT (edge E83):
  - selected_map <= shadow_map, selected_visibility <= shadow_vis (both atomically), puzzle_id <= pid.
  - done=1 for exactly the cycle following E83. busy falls with done. Return to IDLE.
- Latency: load_req accepted at E0 -> done high in the cycle after E83. This is fixed at 84 cycles.
- Empty-mask rule: if shadow_vis is all zero at commit, force bit 0 to 1 and set rom_error. This guarantees the controller leaves its loading state.
- Digit check: a captured digit of 0 or >9 sets rom_error. The digit is still stored unchanged.
- rom_error stays high until the next accepted request.
- load_req while busy is ignored. No queuing.
- A load_req coincident with the COMMIT edge is ignored.
- Changes to difficulty during FETCH have no effect.
- rom_addr holds its last value when not in FETCH.
- Address arithmetic: pid*81 is computed as (pid<<6)+(pid<<4)+pid at ADDR_W bits, with no overflow given the parameter constraint.

Decomposition:
- Shared package sudoku_pkg holds:
  - CELLS=81, DIGIT_W=4, MAP_W=324
  - ROM word field positions (DIGIT_LSB=0, VIS_EASY_BIT=4, VIS_HARD_BIT=5)
  - the loader state encoding
- One sub-module, puzzle_addr_gen: holds the cell counter 0..80 and the base shift-add. It outputs rom_addr and a last-cell flag.
- Capture pipeline, checks and FSM live in puzzle_loader.

Test Plan:
- Reset during FETCH at k=40 -> all outputs 0, state IDLE. A new load_req then completes normally in 84 cycles.
- ROM puzzle 1 holds digit (c%9)+1 with easy bit set on even c. Accept with sel_cnt=1, difficulty=0.
  - Expect rom_addr 81..161 on consecutive cycles.
  - Expect done exactly 84 cycles after acceptance, selected_map[4*10 +: 4]=2, selected_visibility = even-bit pattern, puzzle_id=1.
- Same puzzle with difficulty=1 and hard bits set only on cells 0 and 80 -> selected_visibility = 81'h1_0000_0000_0000_0000_0001.
- Puzzle with all mask bits 0 -> selected_visibility = 1 (bit 0 only), rom_error=1. The next good load clears rom_error.
- Second load_req at cycle 30 of a load, plus a difficulty toggle mid-load -> ignored. Exactly one done pulse, mask uses the latched difficulty.
- Cell 5 digit = 4'hA -> rom_error=1 and selected_map[20 +: 4]=4'hA. sel_cnt with NUM_PUZZLES=3 wraps 2 -> 0.
